// File: rtl/vga_avalon_pkg.sv
// Shared register map, field positions, STATUS bit layout and fill-engine states
// for the queued VGA Avalon front end.
package vga_avalon_pkg;

   localparam logic [3:0] ADDR_PIXEL  = 4'd0;
   localparam logic [3:0] ADDR_RECT_A = 4'd1;
   localparam logic [3:0] ADDR_RECT_B = 4'd2;
   localparam logic [3:0] ADDR_STATUS = 4'd3;

   localparam int COLOUR_LSB = 0;
   localparam int X_LSB      = 8;
   localparam int Y_LSB      = 20;

   localparam int ST_BUSY        = 0;
   localparam int ST_FIFO_FULL   = 1;
   localparam int ST_CLIP_ERR    = 2;
   localparam int ST_FILL_ACTIVE = 3;
   localparam int ST_LEVEL_LSB   = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      RUN   = 2'd2
   } fill_state_t;

endpackage

// File: rtl/vga_avalon_queued_pixel_fifo.sv
// First-word-fall-through pixel FIFO: the head entry is visible on head_o while
// empty_o is low, and pop_i retires it.
module pixel_fifo #(
   parameter int DW    = 23,
   parameter int DEPTH = 16,
   parameter int LW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push_i,
   input  logic [DW-1:0] push_data_i,
   input  logic          pop_i,
   output logic [DW-1:0] head_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [LW-1:0] level_o
);

   localparam int AW = $clog2(DEPTH);

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [LW-1:0] count_q;
   logic          do_push;
   logic          do_pop;

   assign full_o  = (count_q == LW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign level_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

   // Full blocks a push even when a pop retires an entry in the same cycle.
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/vga_avalon_queued.sv
// Avalon-MM slave turning pixel writes and rectangle fills into a pixel stream for
// a vga_adapter. Single pixels are queued; rectangles are rastered in hardware.
//
// state | meaning
// IDLE  | FIFO head drives the stream; a RECT_B write is taken once the FIFO drains
// SETUP | clamp far corner to the screen, flag clipping, drop empty rectangles
// RUN   | emit the rectangle row-major, one pixel per accepted handshake
module vga_avalon_queued
   import vga_avalon_pkg::*;
#(
   parameter int WIDTH      = 160,
   parameter int HEIGHT     = 120,
   parameter int X_W        = 8,
   parameter int Y_W        = 7,
   parameter int COLOUR_W   = 8,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [3:0]          address,
   input  logic                read,
   output logic [31:0]         readdata,
   input  logic                write,
   input  logic [31:0]         writedata,
   output logic                waitrequest,
   output logic                pix_valid,
   input  logic                pix_ready,
   output logic [X_W-1:0]      pix_x,
   output logic [Y_W-1:0]      pix_y,
   output logic [COLOUR_W-1:0] pix_colour
);

   localparam int DW = X_W + Y_W + COLOUR_W;
   localparam int LW = $clog2(FIFO_DEPTH) + 1;

   logic [X_W-1:0]      wd_x;
   logic [Y_W-1:0]      wd_y;
   logic [COLOUR_W-1:0] wd_c;
   logic                wd_unused;

   assign wd_x      = writedata[X_LSB +: X_W];
   assign wd_y      = writedata[Y_LSB +: Y_W];
   assign wd_c      = writedata[COLOUR_LSB +: COLOUR_W];
   assign wd_unused = ^writedata;

   fill_state_t         st_q;
   logic [X_W-1:0]      ra_x0_q;
   logic [Y_W-1:0]      ra_y0_q;
   logic [COLOUR_W-1:0] ra_col_q;
   logic [X_W-1:0]      f_x0_q;
   logic [X_W-1:0]      f_x1_q;
   logic [Y_W-1:0]      f_y0_q;
   logic [Y_W-1:0]      f_y1_q;
   logic [COLOUR_W-1:0] f_col_q;
   logic [X_W-1:0]      cx_q;
   logic [Y_W-1:0]      cy_q;
   logic                clip_err_q;
   logic                clip_err_d;

   logic                fifo_full;
   logic                fifo_empty;
   logic [LW-1:0]       fifo_level;
   logic [DW-1:0]       fifo_head;
   logic                fifo_push;
   logic                fifo_pop;
   logic [X_W-1:0]      head_x;
   logic [Y_W-1:0]      head_y;
   logic [COLOUR_W-1:0] head_c;

   logic wr_pixel, wr_rect_a, wr_rect_b, wr_status;
   logic engine_idle, engine_run;
   logic pixel_stall, rect_b_stall;
   logic pixel_acc, rect_b_acc, pixel_in_range;

   assign wr_pixel  = write && (address == ADDR_PIXEL);
   assign wr_rect_a = write && (address == ADDR_RECT_A);
   assign wr_rect_b = write && (address == ADDR_RECT_B);
   assign wr_status = write && (address == ADDR_STATUS);

   assign engine_idle = (st_q == IDLE);
   assign engine_run  = (st_q == RUN);

   // A fill only starts on an empty FIFO, so queued pixels always precede it.
   assign pixel_stall  = fifo_full || !engine_idle;
   assign rect_b_stall = !engine_idle || !fifo_empty;
   assign waitrequest  = (wr_pixel && pixel_stall) || (wr_rect_b && rect_b_stall);

   assign pixel_acc      = wr_pixel && !pixel_stall;
   assign rect_b_acc     = wr_rect_b && !rect_b_stall;
   assign pixel_in_range = (int'(wd_x) < WIDTH) && (int'(wd_y) < HEIGHT);

   assign fifo_push = pixel_acc && pixel_in_range;
   assign fifo_pop  = !engine_run && !fifo_empty && pix_ready;

   pixel_fifo #(
      .DW    (DW),
      .DEPTH (FIFO_DEPTH),
      .LW    (LW)
   ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .push_i      (fifo_push),
      .push_data_i ({wd_y, wd_x, wd_c}),
      .pop_i       (fifo_pop),
      .head_o      (fifo_head),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .level_o     (fifo_level)
   );

   assign {head_y, head_x, head_c} = fifo_head;

   logic           x1_over, y1_over, setup_reject, setup_clip;
   logic [X_W-1:0] x1_clamped;
   logic [Y_W-1:0] y1_clamped;

   assign x1_over      = int'(f_x1_q) > WIDTH - 1;
   assign y1_over      = int'(f_y1_q) > HEIGHT - 1;
   assign x1_clamped   = x1_over ? X_W'(WIDTH - 1) : f_x1_q;
   assign y1_clamped   = y1_over ? Y_W'(HEIGHT - 1) : f_y1_q;
   assign setup_reject = (f_x0_q > x1_clamped) || (f_y0_q > y1_clamped);
   assign setup_clip   = (st_q == SETUP) && (setup_reject || x1_over || y1_over);

   always_ff @(posedge clk) begin
      if (reset) begin
         st_q    <= IDLE;
         f_x0_q  <= '0;
         f_x1_q  <= '0;
         f_y0_q  <= '0;
         f_y1_q  <= '0;
         f_col_q <= '0;
         cx_q    <= '0;
         cy_q    <= '0;
      end else begin
         case (st_q)
            IDLE: begin
               if (rect_b_acc) begin
                  f_x0_q  <= ra_x0_q;
                  f_y0_q  <= ra_y0_q;
                  f_col_q <= ra_col_q;
                  f_x1_q  <= wd_x;
                  f_y1_q  <= wd_y;
                  st_q    <= SETUP;
               end
            end
            SETUP: begin
               f_x1_q <= x1_clamped;
               f_y1_q <= y1_clamped;
               cx_q   <= f_x0_q;
               cy_q   <= f_y0_q;
               st_q   <= setup_reject ? IDLE : RUN;
            end
            RUN: begin
               if (pix_ready) begin
                  if (cx_q == f_x1_q) begin
                     cx_q <= f_x0_q;
                     cy_q <= cy_q + 1'b1;
                     if (cy_q == f_y1_q) st_q <= IDLE;
                  end else begin
                     cx_q <= cx_q + 1'b1;
                  end
               end
            end
            default: st_q <= IDLE;
         endcase
      end
   end

   // A software clear in the same cycle as a new clip event wins: the write is
   // an explicit acknowledgement of the error state it just observed.
   always_comb begin
      clip_err_d = clip_err_q;
      if (setup_clip || (pixel_acc && !pixel_in_range)) clip_err_d = 1'b1;
      if (wr_status && writedata[ST_CLIP_ERR]) clip_err_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         clip_err_q <= 1'b0;
         ra_x0_q    <= '0;
         ra_y0_q    <= '0;
         ra_col_q   <= '0;
      end else begin
         clip_err_q <= clip_err_d;
         if (wr_rect_a) begin
            ra_x0_q  <= wd_x;
            ra_y0_q  <= wd_y;
            ra_col_q <= wd_c;
         end
      end
   end

   always_comb begin
      pix_valid  = engine_run || !fifo_empty;
      pix_x      = '0;
      pix_y      = '0;
      pix_colour = '0;
      if (engine_run) begin
         pix_x      = cx_q;
         pix_y      = cy_q;
         pix_colour = f_col_q;
      end else if (!fifo_empty) begin
         pix_x      = head_x;
         pix_y      = head_y;
         pix_colour = head_c;
      end
   end

   always_comb begin
      readdata = '0;
      if (read && (address == ADDR_STATUS)) begin
         readdata[ST_BUSY]               = !fifo_empty || !engine_idle;
         readdata[ST_FIFO_FULL]          = fifo_full;
         readdata[ST_CLIP_ERR]           = clip_err_q;
         readdata[ST_FILL_ACTIVE]        = !engine_idle;
         readdata[ST_LEVEL_LSB +: LW]    = fifo_level;
      end
   end

endmodule

// File: tb/tb_vga_avalon_queued.sv
// Bench for vga_avalon_queued: directed scenarios plus random traffic, compared
// against an expected-pixel queue and register model kept inside the bench.
module tb_vga_avalon_queued;

   localparam int W     = 160;
   localparam int H     = 120;
   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  address = '0;
   logic        read = 1'b0;
   logic        write = 1'b0;
   logic [31:0] writedata = '0;
   logic [31:0] readdata;
   logic        waitrequest;
   logic        pix_valid;
   logic        pix_ready = 1'b1;
   logic [7:0]  pix_x;
   logic [6:0]  pix_y;
   logic [7:0]  pix_colour;

   always #5 clk = ~clk;

   vga_avalon_queued #(
      .WIDTH(W), .HEIGHT(H), .X_W(8), .Y_W(7), .COLOUR_W(8), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .reset(reset), .address(address), .read(read), .readdata(readdata),
      .write(write), .writedata(writedata), .waitrequest(waitrequest),
      .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y),
      .pix_colour(pix_colour)
   );

   int checks = 0;
   int failures = 0;

   typedef struct { int x; int y; int c; } pix_t;
   pix_t exp_q[$];
   bit   fill_mode;
   int   fill_delay;
   bit   pend_clip;
   bit   m_clip;
   int   ra_x0, ra_y0, ra_c;
   bit   rand_ready = 1'b0;
   bit   cmp_ev;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
      end
   endfunction

   function automatic void model_reset();
      exp_q.delete();
      fill_mode = 0; fill_delay = 0; pend_clip = 0; m_clip = 0;
      ra_x0 = 0; ra_y0 = 0; ra_c = 0;
   endfunction

   function automatic int fifo_cnt();
      return fill_mode ? 0 : exp_q.size();
   endfunction

   function automatic bit fill_busy();
      return (fill_delay > 0) || (fill_mode && exp_q.size() > 0);
   endfunction

   function automatic bit exp_wait(input logic [3:0] a);
      if (a == 4'd0) return (fifo_cnt() == DEPTH) || fill_busy();
      if (a == 4'd2) return fill_busy() || (fifo_cnt() > 0);
      return 1'b0;
   endfunction

   function automatic logic [31:0] exp_status();
      logic [31:0] s;
      s = '0;
      s[0] = (exp_q.size() > 0) || (fill_delay > 0);
      s[1] = (fifo_cnt() == DEPTH);
      s[2] = m_clip;
      s[3] = fill_busy();
      s[15:8] = 8'(fifo_cnt());
      return s;
   endfunction

   function automatic logic [31:0] mk(input int x, input int y, input int c, input int g);
      logic [31:0] d;
      d = '0;
      d[7:0]   = 8'(c);
      d[15:8]  = 8'(x);
      d[19:16] = 4'(g);
      d[26:20] = 7'(y);
      d[31:27] = 5'(g >> 4);
      return d;
   endfunction

   function automatic void model_accept(input logic [3:0] a, input logic [31:0] d);
      int x, y, c, x1c, y1c;
      x = int'(d[15:8]); y = int'(d[26:20]); c = int'(d[7:0]);
      case (a)
         4'd0: begin
            fill_mode = 0;
            if (x < W && y < H) exp_q.push_back('{x, y, c});
            else m_clip = 1;
         end
         4'd1: begin ra_x0 = x; ra_y0 = y; ra_c = c; end
         4'd2: begin
            fill_mode = 1; fill_delay = 1;
            x1c = (x > W - 1) ? W - 1 : x;
            y1c = (y > H - 1) ? H - 1 : y;
            if (ra_x0 > x1c || ra_y0 > y1c) pend_clip = 1;
            else begin
               pend_clip = (x1c != x) || (y1c != y);
               for (int yy = ra_y0; yy <= y1c; yy++)
                  for (int xx = ra_x0; xx <= x1c; xx++)
                     exp_q.push_back('{xx, yy, ra_c});
            end
         end
         4'd3: if (d[2]) m_clip = 0;
         default: ;
      endcase
   endfunction

   // Every cycle: stream must match the head of the expected-pixel queue.
   always @(negedge clk) begin
      if (!reset) begin
         cmp_ev = (exp_q.size() > 0) && (fill_delay == 0);
         chk("pix_valid", pix_valid, cmp_ev);
         if (cmp_ev && pix_valid === 1'b1) begin
            chk("pix_x", pix_x, exp_q[0].x);
            chk("pix_y", pix_y, exp_q[0].y);
            chk("pix_colour", pix_colour, exp_q[0].c);
            if (pix_ready) void'(exp_q.pop_front());
         end
         if (fill_delay > 0) begin
            fill_delay--;
            if (fill_delay == 0 && pend_clip) m_clip = 1;
         end
      end
   end

   always @(posedge clk) begin
      if (rand_ready) begin
         #1 pix_ready = ($urandom_range(0, 3) != 0);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic av_write(input logic [3:0] a, input logic [31:0] d);
      int   n;
      bit   done;
      logic wr_seen;
      n = 0; done = 0;
      address = a; writedata = d; write = 1'b1;
      while (!done) begin
         #1;
         wr_seen = waitrequest;
         chk("waitrequest", wr_seen, exp_wait(a));
         @(posedge clk); #1;
         if (wr_seen === 1'b0) begin
            model_accept(a, d);
            done = 1;
         end else begin
            n++;
            if (n > 2000) begin
               failures++;
               $display("FAIL write_timeout: addr %0d still stalled after %0d cycles, expected accept", a, n);
               done = 1;
            end
         end
      end
      write = 1'b0;
   endtask

   task automatic av_read(input logic [3:0] a, output logic [31:0] got);
      address = a; read = 1'b1;
      #1;
      got = readdata;
      chk("readdata", got, (a == 4'd3) ? exp_status() : 32'h0);
      @(posedge clk); #1;
      read = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((exp_q.size() > 0 || fill_delay > 0) && n < 3000) begin
         tick(1);
         n++;
      end
      if (n >= 3000) begin
         failures++;
         $display("FAIL drain_timeout: %0d pixels still expected, expected 0", exp_q.size());
      end
      tick(2);
   endtask

   logic [31:0] rd;
   int op, rx, ry;

   initial begin
      model_reset();
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      chk("reset_pix_valid", pix_valid, 1'b0);
      chk("reset_waitrequest", waitrequest, 1'b0);
      chk("reset_pix_xyc", {pix_x, pix_y, pix_colour}, 32'h0);
      av_read(4'd3, rd); chk("reset_status", rd, 32'h0);

      // single pixel
      av_write(4'd0, mk(10, 5, 8'h80, 0));
      chk("model_one_pixel", exp_q.size(), 1);
      wait_idle();
      av_read(4'd3, rd); chk("status_after_pixel", rd, 32'h0);

      // fill FIFO with output stalled, then probe the 17th write
      pix_ready = 1'b0;
      for (int i = 0; i < 16; i++) av_write(4'd0, mk(i * 3, i, 8'h40 + i, 0));
      av_read(4'd3, rd); chk("status_full", rd, 32'h0000_1003);
      address = 4'd0; writedata = mk(99, 77, 8'hEE, 0); write = 1'b1;
      #1 chk("wr_on_17th", waitrequest, 1'b1);
      @(posedge clk); #1;
      write = 1'b0;
      pix_ready = 1'b1;
      av_write(4'd0, mk(99, 77, 8'hEE, 0));
      chk("model_17_queued", exp_q.size() + 0, exp_q.size());
      wait_idle();

      // out-of-range pixel and clip clear
      av_write(4'd0, mk(160, 0, 8'h01, 0));
      tick(3);
      av_read(4'd3, rd); chk("status_clip_pixel", rd, 32'h4);
      av_write(4'd3, 32'h4);
      av_read(4'd3, rd); chk("status_clip_cleared", rd, 32'h0);

      // small rectangle
      av_write(4'd1, mk(2, 3, 8'h11, 0));
      av_write(4'd2, mk(4, 4, 0, 0));
      chk("model_rect_count", exp_q.size(), 6);
      chk("model_rect_first", {exp_q[0].x[15:0], exp_q[0].y[15:0]}, {16'd2, 16'd3});
      chk("model_rect_last", {exp_q[5].x[15:0], exp_q[5].y[15:0]}, {16'd4, 16'd4});
      wait_idle();
      av_read(4'd3, rd); chk("status_after_rect", rd, 32'h0);

      // clamped rectangle
      av_write(4'd1, mk(158, 118, 8'h22, 0));
      av_write(4'd2, mk(200, 119, 0, 0));
      chk("model_clamp_count", exp_q.size(), 4);
      chk("model_clamp_last", {exp_q[3].x[15:0], exp_q[3].y[15:0]}, {16'd159, 16'd119});
      wait_idle();
      av_read(4'd3, rd); chk("status_clamp", rd, 32'h4);
      av_write(4'd3, 32'h4);

      // empty rectangle
      av_write(4'd1, mk(5, 0, 8'h33, 0));
      av_write(4'd2, mk(3, 0, 0, 0));
      chk("model_empty_rect", exp_q.size(), 0);
      wait_idle();
      av_read(4'd3, rd); chk("status_empty_rect", rd, 32'h4);
      av_write(4'd3, 32'h4);

      // reset in the middle of a 10x10 fill
      av_write(4'd1, mk(0, 0, 8'h33, 0));
      av_write(4'd2, mk(9, 9, 0, 0));
      tick(20);
      reset = 1'b1;
      @(posedge clk); #1;
      model_reset();
      reset = 1'b0;
      chk("midreset_pix_valid", pix_valid, 1'b0);
      chk("midreset_pix_xyc", {pix_x, pix_y, pix_colour}, 32'h0);
      av_read(4'd3, rd); chk("midreset_status", rd, 32'h0);
      tick(5);
      av_write(4'd0, mk(7, 7, 8'h5A, 0));
      wait_idle();

      // random traffic
      rand_ready = 1'b1;
      for (int i = 0; i < 300; i++) begin
         op = $urandom_range(0, 19);
         if (op < 11) begin
            av_write(4'd0, mk($urandom_range(0, 170), $urandom_range(0, 125),
                              $urandom_range(0, 255), $urandom_range(0, 511)));
         end else if (op < 13) begin
            av_write(4'd1, mk($urandom_range(0, 165), $urandom_range(0, 125),
                              $urandom_range(0, 255), $urandom_range(0, 511)));
         end else if (op < 15) begin
            rx = ($urandom_range(0, 9) == 0) ? 255 : ra_x0 + $urandom_range(0, 6) - 1;
            ry = ($urandom_range(0, 9) == 0) ? 127 : ra_y0 + $urandom_range(0, 4) - 1;
            if (rx < 0) rx = 0;
            if (ry < 0) ry = 0;
            if (rx > 255) rx = 255;
            if (ry > 127) ry = 127;
            av_write(4'd2, mk(rx, ry, $urandom_range(0, 255), $urandom_range(0, 511)));
         end else if (op < 17) begin
            av_read(4'd3, rd);
         end else if (op < 18) begin
            av_write(4'd3, $urandom());
         end else if (op < 19) begin
            av_read(4'($urandom_range(4, 15)), rd);
         end else begin
            av_write(4'($urandom_range(4, 15)), $urandom());
         end
      end
      rand_ready = 1'b0;
      tick(1);
      pix_ready = 1'b1;
      wait_idle();
      av_read(4'd3, rd);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vga_avalon_queued.md
Name: vga_avalon_queued

Overview:
Parametrised Avalon-MM slave that accepts pixel writes and rectangle-fill commands and emits a pixel stream to a vga_adapter instantiated alongside it. It buffers single pixels in a FIFO and back-pressures the host with waitrequest. A raster fill engine generates clipped rectangles in hardware. STATUS and error registers are readable, replacing the write-only, unbuffered, single-pixel plot path.

Parameters:
WIDTH, 160, visible columns; x valid range is 0..WIDTH-1.
HEIGHT, 120, visible rows; y valid range is 0..HEIGHT-1.
X_W, 8, x coordinate width; must satisfy X_W ≤ 12 and 2^X_W ≥ WIDTH.
Y_W, 7, y coordinate width; must satisfy Y_W ≤ 12 and 2^Y_W ≥ HEIGHT.
COLOUR_W, 8, colour/brightness width; must satisfy COLOUR_W ≤ 8.
FIFO_DEPTH, 16, pixel FIFO entries; must be a power of 2 and ≤ 128.

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-high reset.
address  in  4  Avalon word address.
read  in  1  Avalon read strobe.
readdata  out  32  read data, valid in the same cycle as read (latency 0).
write  in  1  Avalon write strobe.
writedata  in  32  write data.
waitrequest  out  1  stall; a write is accepted only in a cycle where write=1 and waitrequest=0.
pix_valid  out  1  pixel output valid.
pix_ready  in  1  downstream accept; the top level ties this to 1 for vga_adapter.
pix_x  out  X_W  pixel x coordinate.
pix_y  out  Y_W  pixel y coordinate.
pix_colour  out  COLOUR_W  pixel colour.

Behaviour:
- Field format shared by all coordinate registers: colour = wd[COLOUR_W-1:0], x = wd[8+X_W-1:8], y = wd[20+Y_W-1:20]. Unused bits are ignored.
- Register map:
  - 0 PIXEL (write): enqueue one pixel.
  - 1 RECT_A (write): store x0, y0 and colour; no other action.
  - 2 RECT_B (write): store x1, y1 and start a fill.
  - 3 STATUS: read returns [0] busy, [1] fifo_full, [2] clip_err (sticky), [3] fill_active, [15:8] fifo_level. Writing with wd[2]=1 clears clip_err.
  - Other addresses: reads return 0; writes are accepted and ignored.
- Reset: FIFO emptied, fill engine returns to IDLE, RECT_A cleared, clip_err=0. Outputs: pix_valid=0, pix_x/pix_y/pix_colour=0, waitrequest=0. A reset mid-fill aborts the fill; no further pixels are emitted.
- PIXEL write:
  - waitrequest=1 when the FIFO is full or the fill engine is not IDLE.
  - If x≥WIDTH or y≥HEIGHT, the write is accepted, nothing is enqueued, and clip_err is set.
  - A write and a FIFO pop in the same cycle are both honoured; the level is unchanged.
  - A write is never accepted while full, even when a pop occurs in that cycle.
- RECT_B write: waitrequest=1 unless the engine is IDLE and the FIFO is empty. This preserves ordering: earlier pixels drain before the fill starts.
- Fill engine states and transitions:
  - IDLE → SETUP on an accepted RECT_B write.
  - SETUP (1 cycle): clamp x1 to WIDTH-1 and y1 to HEIGHT-1.
    - If x0>x1 or y0>y1 after clamping (this includes x0≥WIDTH or y0≥HEIGHT): set clip_err and go to IDLE, emitting no pixels.
    - If any clamping occurred: set clip_err and still fill the clipped region.
    - Otherwise: go to RUN with cx=x0, cy=y0.
  - RUN: emit (cx, cy, colour) in row-major order, inclusive bounds. Advance one pixel per cycle where pix_valid and pix_ready are both 1. At cx=x1, wrap cx to x0 and increment cy. After the pixel (x1, y1) is accepted, go to IDLE.
- Output mux:
  - In RUN the engine drives pix_*; otherwise the FIFO head drives them.
  - pix_valid = fifo non-empty (not RUN) or RUN.
  - pix_x, pix_y and pix_colour hold stable while pix_valid=1 and pix_ready=0.
- busy = fifo non-empty OR engine not IDLE.
- Reads never stall; STATUS reflects the state before any same-cycle update.

Decomposition:
- Package vga_avalon_pkg holds:
  - register address constants (ADDR_PIXEL=0, ADDR_RECT_A=1, ADDR_RECT_B=2, ADDR_STATUS=3);
  - field LSB constants (COLOUR_LSB=0, X_LSB=8, Y_LSB=20);
  - STATUS bit indices;
  - the fill FSM enum (IDLE, SETUP, RUN).
- Sub-module pixel_fifo: synchronous first-word-fall-through FIFO with push/pop, full/empty and level outputs. Data width is X_W+Y_W+COLOUR_W.

Test Plan:
- Reset, then write PIXEL wd={y=5,x=10,c=0x80} with pix_ready=1 → pix_valid for exactly 1 pixel (10,5,0x80) within 2 cycles; STATUS reads 0.
- pix_ready=0, write 17 pixels back-to-back with FIFO_DEPTH=16 → waitrequest rises on the 17th; STATUS fifo_full=1, level=16. Release pix_ready → 17 pixels out in write order.
- PIXEL x=160, y=0 → no pix_valid; clip_err=1. Write STATUS wd=0x4 → clip_err=0.
- RECT_A {x0=2,y0=3,c=0x11}, RECT_B {x1=4,y1=4} → 6 pixels: (2,3)(3,3)(4,3)(2,4)(3,4)(4,4); fill_active falls afterwards; clip_err=0.
- RECT_A {x0=158,y0=118}, RECT_B {x1=200,y1=119} → 4 pixels ending at (159,119); clip_err=1. RECT_A {x0=5}, RECT_B {x1=3} → 0 pixels; clip_err=1.
- Pulse reset during RUN of a 10x10 fill → pix_valid=0 the cycle after reset, STATUS=0, no further pixels; a following PIXEL write is accepted normally.
